// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Bit positions inside the err vector.
  localparam int ERR_DIV0 = 0;
  localparam int ERR_OVF  = 1;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_nr_param_if.sv
// Handshake and result bundle of div_nr_param. The err field exists only when DIV_ERR_EN is defined.
interface div_nr_param_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             sign_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
`ifdef DIV_ERR_EN
  logic [1:0]       err;
`endif

  modport master (
    output start, sign_mode, dividend, divisor,
    input  q, r, busy, done
`ifdef DIV_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  start, sign_mode, dividend, divisor,
    output q, r, busy, done
`ifdef DIV_ERR_EN
    , output err
`endif
  );

endinterface

// File: rtl/div_nr_step.sv
// One combinational non-restoring iteration on a WIDTH+1 bit partial remainder.
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  input  logic             neg_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Dropping rem_in's top bit is safe: the true result always fits, so modular arithmetic is exact.
  assign shifted = {rem_in[WIDTH-1:0], quo_msb};
  assign rem_out = neg_in ? shifted + {1'b0, divisor} : shifted - {1'b0, divisor};
  assign q_bit   = ~rem_out[WIDTH];

endmodule

// File: rtl/div_nr_param.sv
// Iterative signed/unsigned non-restoring divider: WIDTH+1 cycles per op.
// Optional DIV_ERR_EN adds the err flags and a two-cycle fast path for divide-by-zero and overflow.
module div_nr_param #(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  div_nr_param_if.slave bus
);
  import div_pkg::*;

  localparam int               CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, b_mag, a_raw;
  logic             neg_q, neg_r, div0, ovf;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic             busy_reg, done_reg;
  logic [WIDTH:0]   step_rem, rem_fix;
  logic             step_bit;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in, q_fix, r_fix;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_msb (quo[WIDTH-1]),
    .divisor (b_mag),
    .neg_in  (rem[WIDTH]),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign a_neg    = bus.sign_mode & bus.dividend[WIDTH-1];
  assign b_neg    = bus.sign_mode & bus.divisor[WIDTH-1];
  assign a_mag_in = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag_in = b_neg ? -bus.divisor  : bus.divisor;

  assign rem_fix = rem[WIDTH] ? rem + {1'b0, b_mag} : rem;
  assign q_fix   = div0 ? '1    : ovf ? MIN_VAL : (neg_q ? -quo : quo);
  assign r_fix   = div0 ? a_raw : ovf ? '0
                 : (neg_r ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0]);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
`ifdef DIV_ERR_EN
        if (div0 || ovf) state_next = FIX;
        else
`endif
        if (cnt == LAST) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      q_reg    <= '0;
      r_reg    <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
`ifdef DIV_ERR_EN
      bus.err  <= 2'b00;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_raw    <= bus.dividend;
          quo      <= a_mag_in;
          b_mag    <= b_mag_in;
          rem      <= '0;
          cnt      <= '0;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          div0     <= (bus.divisor == '0);
          ovf      <= bus.sign_mode && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
          busy_reg <= 1'b1;
`ifdef DIV_ERR_EN
          bus.err  <= 2'b00;
`endif
        end
        RUN: begin
          rem <= step_rem;
          quo <= {quo[WIDTH-2:0], step_bit};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          q_reg    <= q_fix;
          r_reg    <= r_fix;
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
`ifdef DIV_ERR_EN
          bus.err[ERR_DIV0] <= div0;
          bus.err[ERR_OVF]  <= ovf;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_div_nr_param.sv
// Directed bench for div_nr_param at WIDTH=32 and WIDTH=8; honours DIV_ERR_EN when defined.
module tb_div_nr_param;

`ifdef DIV_ERR_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sel8    = 1'b0;

  always #5 clock = ~clock;

  div_nr_param_if #(.WIDTH(32)) bus32 ();
  div_nr_param_if #(.WIDTH(8))  bus8 ();

  div_nr_param #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  div_nr_param #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  logic [31:0] cur_q, cur_r;
  logic        cur_busy, cur_done;
  assign cur_q    = sel8 ? {24'h0, bus8.q} : bus32.q;
  assign cur_r    = sel8 ? {24'h0, bus8.r} : bus32.r;
  assign cur_busy = sel8 ? bus8.busy : bus32.busy;
  assign cur_done = sel8 ? bus8.done : bus32.done;
`ifdef DIV_ERR_EN
  logic [1:0] cur_err;
  assign cur_err = sel8 ? bus8.err : bus32.err;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents operands before a rising edge (E0) and returns #1 after E0 with start released.
  task automatic launch(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    sel8 = w8;
    if (w8) begin
      bus8.start = 1'b1; bus8.sign_mode = sgn; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
    end else begin
      bus32.start = 1'b1; bus32.sign_mode = sgn; bus32.dividend = a; bus32.divisor = b;
    end
    @(posedge clock); #1;
    bus8.start  = 1'b0;
    bus32.start = 1'b0;
  endtask

  // poke > 0: a stray 32-bit start with different operands is sampled at E0+poke.
  task automatic do_op(input string tag, input bit w8, input bit sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input logic [31:0] exp_r,
                       input int exp_lat, input logic [1:0] exp_err, input int poke);
    int lat;
    int busy_cnt;
    launch(w8, sgn, a, b);
    check({tag, " busy@E0"}, cur_busy, 1'b1);
    check({tag, " done pulse low@E0"}, cur_done, 1'b0);
`ifdef DIV_ERR_EN
    check({tag, " err cleared@E0"}, cur_err, 2'b00);
`endif
    lat = 0;
    busy_cnt = 1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (poke > 0) begin
        if (n == poke - 1) begin
          bus32.start = 1'b1; bus32.sign_mode = 1'b1;
          bus32.dividend = 32'hDEAD_BEEF; bus32.divisor = 32'd3;
        end else begin
          bus32.start = 1'b0;
        end
      end
      if (cur_done) begin
        lat = n;
        break;
      end
      if (cur_busy) busy_cnt++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " busy low@done"}, cur_busy, 1'b0);
    check({tag, " q"}, cur_q, exp_q);
    check({tag, " r"}, cur_r, exp_r);
`ifdef DIV_ERR_EN
    check({tag, " err"}, cur_err, exp_err);
`endif
  endtask

  initial begin
    bus32.start = 1'b0; bus32.sign_mode = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
    bus8.start  = 1'b0; bus8.sign_mode  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy32", bus32.busy, 1'b0);
    check("reset done32", bus32.done, 1'b0);
    check("reset q32", bus32.q, 32'h0);
    check("reset r32", bus32.r, 32'h0);
    check("reset busy8", bus8.busy, 1'b0);
    check("reset q8", bus8.q, 8'h0);
`ifdef DIV_ERR_EN
    check("reset err32", bus32.err, 2'b00);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    // Consecutive do_op calls start on the done cycle, so each one after the first is back-to-back.
    do_op("u100/7",      1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 2'b00, 0);
    do_op("s-7/2",       1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 2'b00, 0);
    do_op("s7/-2",       1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 2'b00, 0);
    do_op("u5/0",        1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, SPEC_LAT, 2'b01, 0);
    do_op("s-5/0",       1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, SPEC_LAT, 2'b01, 0);
    do_op("s min/-1",    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, SPEC_LAT, 2'b10, 0);
    do_op("u min/max",   1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 2'b00, 0);
    do_op("u8 200/3",    1'b1, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 9, 2'b00, 0);
    do_op("s8 -56/3",    1'b1, 1'b1, 32'hC8, 32'd3, 32'hEE, 32'hFE, 9, 2'b00, 0);
    do_op("stray start", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 2'b00, 5);

    repeat (3) @(posedge clock);
    #1;
    check("idle hold q", bus32.q, 32'd14);
    check("idle hold r", bus32.r, 32'd2);
    check("idle done low", bus32.done, 1'b0);

    begin
      logic any_done;
      any_done = 1'b0;
      launch(1'b0, 1'b0, 32'd1000, 32'd3);
      for (int n = 1; n <= 9; n++) begin
        @(posedge clock); #1;
        any_done = any_done | bus32.done;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort busy", bus32.busy, 1'b0);
      check("abort q", bus32.q, 32'h0);
      check("abort r", bus32.r, 32'h0);
      check("abort done", bus32.done | any_done, 1'b0);
      reset = 1'b0;
    end
    do_op("after reset s7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 2'b00, 0);
    @(posedge clock); #1;
    check("done is pulse", bus32.done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
